// File: rtl/gomoku_pkg.sv
// Shared encodings for the cursor/placement controller: board default,
// stone codes as stored in board memory, controller states and player.
package gomoku_pkg;

    localparam int BOARD_N_DEF = 15;

    typedef enum logic [1:0] {
        STONE_EMPTY = 2'b00,
        STONE_BLACK = 2'b01,
        STONE_WHITE = 2'b10
    } stone_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CHK,
        ST_WR,
        ST_REJ
    } state_e;

    typedef enum logic {
        PL_BLACK = 1'b0,
        PL_WHITE = 1'b1
    } player_e;

    function automatic stone_e stone_of(input player_e p);
        return (p == PL_WHITE) ? STONE_WHITE : STONE_BLACK;
    endfunction

endpackage

// File: rtl/coord_step.sv
// One cursor axis: applies an inc/dec pulse with wrap or clamp at the board edge.
// Simultaneous inc and dec cancel.
module coord_step #(
    parameter int BOARD_N = 15,
    parameter int WRAP    = 1,
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0] coord,
    input  logic               inc,
    input  logic               dec,
    output logic [COORD_W-1:0] coord_nxt
);

    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(BOARD_N - 1);

    always_comb begin
        coord_nxt = coord;
        if (inc && !dec) begin
            if (coord == MAX_C) coord_nxt = (WRAP != 0) ? '0 : MAX_C;
            else                coord_nxt = coord + COORD_W'(1);
        end else if (dec && !inc) begin
            if (coord == '0)    coord_nxt = (WRAP != 0) ? MAX_C : '0;
            else                coord_nxt = coord - COORD_W'(1);
        end
    end

endmodule

// File: rtl/cursor_place_ctrl.sv
// Board cursor, player-to-move and the read-check-write stone placement
// handshake against an external board memory with one-cycle read latency.
module cursor_place_ctrl
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEF,
    parameter int WRAP    = 1,
    parameter int COORD_W = 4,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    input  logic               center,
    input  logic               game_over,
    output logic [ADDR_W-1:0]  brd_addr,
    output logic               brd_rd_en,
    input  logic [1:0]         brd_rdata,
    output logic               brd_we,
    output logic [1:0]         brd_wdata,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               player,
    output logic               busy,
    output logic               place_ok,
    output logic               place_rej,
    output logic [ADDR_W-1:0]  move_cnt,
    output logic               board_full
);

    localparam logic [ADDR_W-1:0]  CELLS = ADDR_W'(BOARD_N * BOARD_N);
    localparam logic [ADDR_W-1:0]  N_A   = ADDR_W'(BOARD_N);
    localparam logic [COORD_W-1:0] MID   = COORD_W'(BOARD_N / 2);

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]  x_step, y_step;
    player_e             player_q, player_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    coord_step #(.BOARD_N(BOARD_N), .WRAP(WRAP), .COORD_W(COORD_W)) u_step_x (
        .coord(x_q), .inc(right), .dec(left), .coord_nxt(x_step)
    );

    coord_step #(.BOARD_N(BOARD_N), .WRAP(WRAP), .COORD_W(COORD_W)) u_step_y (
        .coord(y_q), .inc(down), .dec(up), .coord_nxt(y_step)
    );

    assign board_full = (cnt_q == CELLS);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        player_d = player_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        case (state_q)
            ST_IDLE: begin
                // centre wins over any direction pulse in the same cycle
                if (center) begin
                    if (game_over || board_full) begin
                        state_d = ST_REJ;
                    end else begin
                        addr_d  = ADDR_W'(y_q) * N_A + ADDR_W'(x_q);
                        state_d = ST_RD;
                    end
                end else begin
                    x_d = x_step;
                    y_d = y_step;
                end
            end
            ST_RD:  state_d = ST_CHK;
            ST_CHK: state_d = (brd_rdata == STONE_EMPTY) ? ST_WR : ST_REJ;
            ST_WR: begin
                player_d = (player_q == PL_BLACK) ? PL_WHITE : PL_BLACK;
                if (cnt_q != CELLS) cnt_d = cnt_q + ADDR_W'(1);
                state_d  = ST_IDLE;
            end
            ST_REJ:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= MID;
            y_q      <= MID;
            player_q <= PL_BLACK;
            cnt_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            player_q <= player_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
        end
    end

    assign brd_addr  = addr_q;
    assign brd_rd_en = (state_q == ST_RD);
    assign brd_we    = (state_q == ST_WR);
    assign brd_wdata = (state_q == ST_WR) ? stone_of(player_q) : STONE_EMPTY;
    assign place_ok  = (state_q == ST_WR);
    assign place_rej = (state_q == ST_REJ);
    assign busy      = (state_q != ST_IDLE);
    assign cur_x     = x_q;
    assign cur_y     = y_q;
    assign player    = player_q;
    assign move_cnt  = cnt_q;

endmodule

// File: doc/cursor_place_ctrl.md
Name: cursor_place_ctrl

Overview:
- Consumes the single-cycle, debounced direction and centre pulses produced by the button-handling stage.
- Maintains the board cursor and the player to move.
- On a centre press, runs a read-check-write handshake against the external board-state memory to place a stone.
- Feeds the board memory, the display renderer and the downstream win checker.

Parameters:
- BOARD_N, 15: board edge length; legal coordinates 0..BOARD_N-1.
- WRAP, 1: 1 = cursor wraps at edges; 0 = cursor clamps at edges.
- COORD_W, 4: coordinate width; requires 2^COORD_W >= BOARD_N.
- ADDR_W, 8: board address width; requires 2^ADDR_W >= BOARD_N*BOARD_N.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- left, right, up, down, center  in  1 each  one-cycle pulses, synchronous to clk.
- game_over  in  1  level; blocks placement while high.
- brd_addr  out  ADDR_W  board address = y*BOARD_N + x.
- brd_rd_en  out  1  read strobe; memory returns brd_rdata exactly one cycle later.
- brd_rdata  in  2  stone at address: 00 empty, 01 black, 10 white.
- brd_we  out  1  write strobe.
- brd_wdata  out  2  stone to write.
- cur_x, cur_y  out  COORD_W each  cursor position.
- player  out  1  0 = black to move, 1 = white to move.
- busy  out  1  high while not IDLE.
- place_ok  out  1  one-cycle pulse on a successful write.
- place_rej  out  1  one-cycle pulse on a refused placement.
- move_cnt  out  ADDR_W  stones placed so far.
- board_full  out  1  move_cnt == BOARD_N*BOARD_N.

Behaviour:
- Reset values (asynchronous on rst):
  - cur_x = cur_y = BOARD_N/2 (7,7); player = 0; move_cnt = 0; state = IDLE.
  - All strobes and pulses = 0; brd_addr = 0; brd_wdata = 00.
- State machine: IDLE, RD, CHK, WR, REJ.
- Cursor movement, IDLE only:
  - right: x+1; left: x-1; down: y+1; up: y-1.
  - Edge: WRAP=1 gives 0 <-> BOARD_N-1 wrap-around; WRAP=0 saturates at the edge.
  - left & right in the same cycle: x unchanged. up & down in the same cycle: y unchanged.
  - Direction pulses arriving outside IDLE are dropped, not queued.
- Centre press sampled at edge k while IDLE:
  - center has priority: direction pulses in the same cycle are dropped.
  - If game_over=1 or board_full=1: go to REJ.
  - Otherwise latch address from the current x,y and go to RD.
  - Address is held constant from RD through WR even though cursor cannot move.
- Centre press outside IDLE: ignored.
- Cycle-level sequence after centre at edge k:
  - k+1 RD: brd_rd_en=1, brd_addr valid.
  - k+2 CHK: brd_rdata valid. 00 -> WR; anything else -> REJ.
  - k+3 WR: brd_we=1, brd_wdata = player ? 10 : 01, place_ok=1.
  - End of WR: player toggles, move_cnt+1, state -> IDLE.
  - k+3 REJ (occupied cell): place_rej=1 for one cycle, then IDLE. player and move_cnt unchanged.
  - REJ for game_over/full: place_rej asserted at k+1.
- Total latency: accept-to-IDLE = 4 cycles; reject on occupied cell = 4 cycles.
- move_cnt saturates at BOARD_N*BOARD_N; board_full is combinational from move_cnt.
- rst mid-operation: aborts immediately. No write is issued if rst asserts before WR; any partially completed sequence is discarded.
- brd_addr arithmetic: computed at ADDR_W width, no truncation for legal coordinates.

Decomposition:
- gomoku_pkg holds:
  - BOARD_N default.
  - Stone encodings EMPTY/BLACK/WHITE.
  - State enum.
  - Player encoding.
- Sub-module coord_step (one axis):
  - Inputs: coordinate, inc, dec, WRAP, BOARD_N.
  - Output: next coordinate.
  - Instantiated twice, for x and y.

Test Plan:
- Reset, then 8 right pulses with WRAP=1 -> cur_x goes 8..14, then 0; cur_y = 7.
- WRAP=0, x=0, left pulse -> cur_x stays 0. left+right in same cycle from x=5 -> cur_x = 5.
- Centre at (3,2), memory returns 00:
  - brd_rd_en at k+1 with brd_addr = 33.
  - brd_we, brd_wdata=01 and place_ok at k+3.
  - Afterwards player=1, move_cnt=1.
- Second centre at the same cell, memory returns 01 -> place_rej at k+3, no brd_we, player and move_cnt unchanged.
- game_over=1 + centre -> place_rej at k+1, no memory access. Right pulse during busy -> cur_x unchanged.
- rst asserted during CHK -> outputs reset within the same cycle, no brd_we ever seen. Force move_cnt=225 -> board_full=1 and centre is rejected.
